fetch_unit: RTL

Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of the main control decoder. Holds the program counter, requests instruction words from instruction memory over a ready-handshaked port, and presents the fetched word (and its opcode field) to control and the register file for one execute cycle. Consumes the decoder's Jump/Branch outputs and the ALU Zero flag to compute the next PC at the end of each executed instruction.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/next_pc_calc.sv | 47 ++++
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the single-cycle MIPS datapath:
//                opcode constants, instruction width, PC reset default,
//                fetch FSM state type and a sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int INSTR_W = 32;

    // Default PC after reset; must be word aligned.
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // Primary opcode field values (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC selection for the fetch stage.
//                Priority: Jump > (Branch & Zero) > sequential.
//  Ports       : pc_plus4 (in 32)  - address of the following word
//                instr    (in 32)  - instruction currently executing
//                Jump, Branch, Zero (in 1) - decoder / ALU flags
//                next_pc  (out 32) - PC of the next instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               Zero,
    output logic [31:0]        next_pc
);

    logic [31:0] w_jump_target;
    logic [31:0] w_imm_ext;
    logic [31:0] w_branch_target;
    logic        w_unused_opcode;

    // Opcode bits are decoded upstream; only the immediate/target fields matter here.
    assign w_unused_opcode = ^instr[31:26];

    always_comb begin
        // Jump keeps the 256 MB region of the following instruction.
        w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
        w_imm_ext       = sign_ext16(instr[15:0]);
        w_branch_target = pc_plus4 + {w_imm_ext[29:0], 2'b00};

        if (Jump) begin
            next_pc = w_jump_target;
        end else if (Branch && Zero) begin
            next_pc = w_branch_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage of the single-cycle MIPS datapath.
//                Two-state FSM (FETCH, EXEC). FETCH requests the word at pc
//                until imem_ready; EXEC presents it for one or more cycles
//                (extended by stall) and then updates pc from next_pc_calc.
//  Ports       : clk, rst (async, active high)
//                imem_req/imem_addr out, imem_ready/imem_rdata in
//                stall, Jump, Branch, Zero in
//                instr, opcode, instr_valid, pc, pc_plus4 out
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               Zero,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4
);

    // Low bits forced to zero so pc stays word aligned whatever the parameter.
    localparam logic [31:0] PC_RESET_ALIGNED = {PC_RESET[31:2], 2'b00};

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               imem_req_q, imem_req_d;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_next_pc;

    assign w_pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (w_pc_plus4),
        .instr    (instr_q),
        .Jump     (Jump),
        .Branch   (Branch),
        .Zero     (Zero),
        .next_pc  (w_next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        case (state_q)
            ST_FETCH: begin
                // imem_ready only counts while a request is actually
                // presented; this discards a ready arriving in the
                // post-reset cycle before the request goes out.
                if (imem_req_q && imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d    = w_next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Outputs are registered versions of the next state's decode.
        instr_valid_d = (state_d == ST_EXEC);
        imem_req_d    = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= PC_RESET_ALIGNED;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = w_pc_plus4;

endmodule
`default_nettype wire
